// File: rtl/pwm_pkg.sv
// Shared constants, FSM state type and position decode for the servo PWM link.
package pwm_pkg;

    localparam int unsigned CLK_PER_US   = 50;
    localparam int unsigned PERIOD_US    = 20000;
    localparam int unsigned TIMEOUT_US   = 25000;
    localparam int unsigned MIN_PULSE_US = 500;
    localparam int unsigned MAX_PULSE_US = 2500;
    localparam int unsigned CNT_W        = 15;

    localparam logic [CNT_W-1:0] NOM_W0 = 15'd1000;
    localparam logic [CNT_W-1:0] NOM_W1 = 15'd1333;
    localparam logic [CNT_W-1:0] NOM_W2 = 15'd1666;
    localparam logic [CNT_W-1:0] NOM_W3 = 15'd2000;

    // Midpoints between adjacent nominal widths, rounded up.
    localparam logic [CNT_W-1:0] THR_01 = 15'd1167;
    localparam logic [CNT_W-1:0] THR_12 = 15'd1500;
    localparam logic [CNT_W-1:0] THR_23 = 15'd1833;

    typedef enum logic [1:0] {
        StSync,
        StWaitRise,
        StHigh,
        StLow
    } pwm_state_e;

    function automatic logic [1:0] decode_pos(input logic [CNT_W-1:0] w);
        if (w < THR_01) begin
            return 2'd0;
        end else if (w < THR_12) begin
            return 2'd1;
        end else if (w < THR_23) begin
            return 2'd2;
        end else begin
            return 2'd3;
        end
    endfunction

endpackage

// File: rtl/pwm_in_sync.sv
// Two-flop synchronizer for the servo input plus registered rise/fall strobes.
module pwm_in_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_q, sync_q, dly_q, rise_q, fall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            dly_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            meta_q <= pwm_in;
            sync_q <= meta_q;
            dly_q  <= sync_q;
            rise_q <= sync_q & ~dly_q;
            fall_q <= ~sync_q & dly_q;
        end
    end

    // Level is taken from the delayed copy so it lines up with the edge strobes.
    assign level = dly_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/pwm_decoder.sv
// Servo pulse receiver: measures each high pulse in microseconds and decodes it to a
// 2-bit position code, with lock tracking and a rise-to-rise timeout.
module pwm_decoder #(
    parameter int unsigned CLK_PER_US   = pwm_pkg::CLK_PER_US,
    parameter int unsigned TIMEOUT_US   = pwm_pkg::TIMEOUT_US,
    parameter int unsigned MIN_PULSE_US = pwm_pkg::MIN_PULSE_US,
    parameter int unsigned MAX_PULSE_US = pwm_pkg::MAX_PULSE_US
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      pwm_in,
    output logic [1:0]                pos,
    output logic [pwm_pkg::CNT_W-1:0] width_us,
    output logic                      valid,
    output logic                      err,
    output logic                      locked
);
    import pwm_pkg::*;

    localparam int unsigned        PW       = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [PW-1:0]      PRE_LAST = PW'(CLK_PER_US - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]   TO_LIM   = CNT_W'(TIMEOUT_US);
    localparam logic [CNT_W-1:0]   W_MIN    = CNT_W'(MIN_PULSE_US);
    localparam logic [CNT_W-1:0]   W_MAX    = CNT_W'(MAX_PULSE_US);

    logic level, rise, fall;

    pwm_in_sync u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_in (pwm_in),
        .level  (level),
        .rise   (rise),
        .fall   (fall)
    );

    pwm_state_e       state_q, state_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic [CNT_W-1:0] hi_q, hi_d, hi_inc, hi_eval;
    logic [CNT_W-1:0] per_q, per_d, per_inc;
    logic [1:0]       flush_q, flush_d;
    logic             to_done_q, to_done_d;
    logic [1:0]       pos_q, pos_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic             valid_q, valid_d, err_q, err_d, locked_q, locked_d;
    logic             tick, eval, pass, to_fire;

    assign tick    = (pre_q == PRE_LAST);
    assign hi_inc  = (hi_q == CNT_MAX) ? hi_q : hi_q + 1'b1;
    assign per_inc = (per_q == CNT_MAX) ? per_q : per_q + 1'b1;
    // Include the tick landing on the falling-edge cycle so N us of high reads as N.
    assign hi_eval = (state_q == StHigh && tick) ? hi_inc : hi_q;

    always_comb begin
        pre_d     = (rise || tick) ? '0 : pre_q + 1'b1;
        hi_d      = rise ? '0 : hi_eval;
        per_d     = rise ? '0 : (tick ? per_inc : per_q);
        flush_d   = (flush_q == 2'd3) ? flush_q : flush_q + 2'd1;
        state_d   = state_q;
        eval      = 1'b0;

        unique case (state_q)
            // Flush waits out the synchronizer so a pulse already high at reset is skipped.
            StSync:     if (flush_q == 2'd3 && !level) state_d = StWaitRise;
            StWaitRise: if (rise) state_d = StHigh;
            StLow:      if (rise) state_d = StHigh;
            StHigh: begin
                if (fall) begin
                    state_d = StLow;
                    eval    = 1'b1;
                end
            end
            default:    state_d = StSync;
        endcase

        // Evaluation and a coincident rise both take precedence; a blocked timeout retries.
        to_fire   = (per_q >= TO_LIM) && !to_done_q && !rise && !eval && (state_q != StSync);
        to_done_d = rise ? 1'b0 : (to_done_q | to_fire);
        if (to_fire && state_q != StHigh) state_d = StWaitRise;

        pass     = eval && (hi_eval >= W_MIN) && (hi_eval <= W_MAX);
        valid_d  = pass;
        err_d    = (eval && !pass) || to_fire;
        pos_d    = pass ? decode_pos(hi_eval) : pos_q;
        width_d  = pass ? hi_eval : width_q;
        locked_d = pass ? 1'b1 : (to_fire ? 1'b0 : locked_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StSync;
            pre_q     <= '0;
            hi_q      <= '0;
            per_q     <= '0;
            flush_q   <= '0;
            to_done_q <= 1'b0;
            pos_q     <= '0;
            width_q   <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            hi_q      <= hi_d;
            per_q     <= per_d;
            flush_q   <= flush_d;
            to_done_q <= to_done_d;
            pos_q     <= pos_d;
            width_q   <= width_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            locked_q  <= locked_d;
        end
    end

    assign pos      = pos_q;
    assign width_us = width_q;
    assign valid    = valid_q;
    assign err      = err_q;
    assign locked   = locked_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// Scoreboard bench for pwm_decoder with a scaled clock rate and timeout.
module tb_pwm_decoder;

    localparam int unsigned C   = 2;
    localparam int unsigned TO  = 3500;
    localparam int unsigned GAP = 50 * C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pwm_in = 1'b0;
    logic [1:0]  pos;
    logic [14:0] width_us;
    logic        valid, err, locked;

    pwm_decoder #(
        .CLK_PER_US (C),
        .TIMEOUT_US (TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pwm_in   (pwm_in),
        .pos      (pos),
        .width_us (width_us),
        .valid    (valid),
        .err      (err),
        .locked   (locked)
    );

    always #10 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        logic [1:0]  pos;
        logic [14:0] width;
        bit          locked;
        int unsigned at;
        int unsigned slack;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    bit          m_locked = 1'b0;
    logic [1:0]  m_pos = 2'd0;
    logic [14:0] m_width = 15'd0;

    function automatic void check(string name, longint act, longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference decode: nearest nominal width, ties go to the longer one.
    function automatic logic [1:0] ref_pos(int unsigned w);
        int unsigned nom[4] = '{1000, 1333, 1666, 2000};
        int unsigned best_d = 32'hFFFF_FFFF;
        logic [1:0]  best = 2'd0;
        for (int i = 0; i < 4; i++) begin
            int unsigned d = (w > nom[i]) ? w - nom[i] : nom[i] - w;
            if (d <= best_d) begin
                best_d = d;
                best   = 2'(i);
            end
        end
        return best;
    endfunction

    always @(negedge clk) begin
        if (rst_n && (valid || err)) begin
            exp_t e;
            check("valid_err_exclusive", valid && err, 0);
            if (sb.size() == 0) begin
                check("unexpected_strobe", 1, 0);
            end else begin
                e = sb.pop_front();
                check("strobe_kind_err", err, e.is_err);
                check("pos", pos, e.pos);
                check("width_us", width_us, e.width);
                check("locked", locked, e.locked);
                vectors++;
                if ((cyc > e.at ? cyc - e.at : e.at - cyc) > e.slack) begin
                    miscompares++;
                    $display("FAIL strobe_cycle: got %0d, expected %0d +/- %0d", cyc, e.at, e.slack);
                end
            end
        end
    end

    task automatic check_zero(string name);
        check({name, "_pos"}, pos, 0);
        check({name, "_width"}, width_us, 0);
        check({name, "_valid"}, valid, 0);
        check({name, "_err"}, err, 0);
        check({name, "_locked"}, locked, 0);
    endtask

    task automatic drive_pulse(int unsigned hi_cyc, int unsigned lo_cyc, bit expect_to);
        int unsigned rise_at, fall_at, w;
        exp_t e;
        @(negedge clk);
        pwm_in  = 1'b1;
        rise_at = cyc;
        repeat (hi_cyc) @(negedge clk);
        pwm_in  = 1'b0;
        fall_at = cyc;
        w = hi_cyc / C;
        if (w >= 500 && w <= 2500) begin
            m_pos    = ref_pos(w);
            m_width  = 15'(w);
            m_locked = 1'b1;
            e.is_err = 1'b0;
        end else begin
            e.is_err = 1'b1;
        end
        e.pos = m_pos; e.width = m_width; e.locked = m_locked;
        e.at = fall_at + 4; e.slack = 0;
        sb.push_back(e);
        if (expect_to) begin
            m_locked = 1'b0;
            e.is_err = 1'b1; e.pos = m_pos; e.width = m_width; e.locked = 1'b0;
            e.at = rise_at + C * TO + 5; e.slack = C + 6;
            sb.push_back(e);
        end
        repeat (lo_cyc) @(negedge clk);
    endtask

    initial begin
        int unsigned sweep[7] = '{1334, 1667, 2001, 1166, 1167, 1832, 1833};
        pwm_in = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        // Partial pulse already high at reset release must be discarded.
        repeat (800 * C) @(negedge clk);
        pwm_in = 1'b0;
        repeat (GAP) @(negedge clk);
        drive_pulse(1001 * C, GAP, 1'b0);
        drive_pulse(1001 * C, GAP, 1'b0);
        for (int i = 0; i < 3; i++) drive_pulse(sweep[i] * C, GAP, 1'b0);
        drive_pulse(300 * C, GAP, 1'b0);
        drive_pulse(3000 * C, GAP, 1'b0);
        drive_pulse(1001 * C, C * TO + 400, 1'b1);
        drive_pulse(1001 * C, GAP, 1'b0);
        for (int i = 3; i < 7; i++) drive_pulse(sweep[i] * C, GAP, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive_pulse($urandom_range(200, 3200) * C + $urandom_range(0, C - 1), GAP, 1'b0);
        end
        // Reset in the middle of a pulse.
        @(negedge clk);
        pwm_in = 1'b1;
        repeat (400 * C) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_locked = 1'b0; m_pos = 2'd0; m_width = 15'd0;
        repeat (300 * C) @(negedge clk);
        pwm_in = 1'b0;
        repeat (GAP) @(negedge clk);
        drive_pulse(1501 * C, GAP, 1'b0);
        repeat (20) @(negedge clk);
        check("pending_expectations", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pwm_decoder.md
# pwm_decoder

Servo-pulse receiver for the PWM link: samples an incoming 20 ms-period servo signal, measures each high pulse in microseconds on a 50 MHz clock, and decodes it back to the 2-bit position code (1.000 / 1.333 / 1.666 / 2.000 ms). Sits at the far end of the PWM generator's output line and feeds position and health flags to downstream control logic.

## Interface
- CLK_PER_US, 50, clock cycles per microsecond tick
- TIMEOUT_US, 25000, max µs between rising edges before lock is lost
- MIN_PULSE_US, 500, shortest legal high pulse (inclusive)
- MAX_PULSE_US, 2500, longest legal high pulse (inclusive)
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous, active-low reset
- pwm_in  in  1  asynchronous servo PWM input
- pos  out  2  last valid decoded position code
- width_us  out  15  last valid measured high width, µs
- valid  out  1  one-cycle strobe: pos/width_us updated
- err  out  1  one-cycle strobe: illegal pulse or timeout
- locked  out  1  high while pulses arrive within TIMEOUT_US

## Operation
- pwm_in passes a 2-FF synchronizer; edges detected from sync output vs. one-cycle-delayed copy.
- µs prescaler counts 0..CLK_PER_US-1, cleared on every detected rising edge; tick on terminal count.
- hi_cnt (15 b, saturating at 32767): cleared on rise, +1 per tick while high.
- per_cnt (15 b, saturating): cleared on rise, +1 per tick in any state.
- FSM states: SYNC (after reset, wait for pwm low), WAIT_RISE, HIGH, LOW.
  - SYNC -> WAIT_RISE when synchronized input is 0 (discards a partial pulse after reset).
  - WAIT_RISE/LOW -> HIGH on rising edge.
  - HIGH -> LOW on falling edge; evaluate hi_cnt.
- Evaluation: MIN_PULSE_US ≤ hi_cnt ≤ MAX_PULSE_US -> width_us=hi_cnt, pos per thresholds, valid strobe; else err strobe, pos/width_us hold.
- Thresholds (midpoints): <1167 -> 00; 1167..1499 -> 01; 1500..1832 -> 10; ≥1833 -> 11.
- locked: set on first valid; cleared when per_cnt reaches TIMEOUT_US (err strobe once, FSM -> WAIT_RISE, or stays HIGH if input stuck high, then err again only on next rise-cycle timeout).
- A stuck-high input saturating hi_cnt yields err at the eventual fall (width > MAX).

## Timing
- Reset values: pos=00, width_us=0, valid=0, err=0, locked=0, FSM=SYNC, all counters 0.
- Latency: pwm_in edge -> edge-detect = 3 clk (2 sync + 1 compare). valid/err registered 1 clk after edge-detect, i.e. 4 clk after pwm_in fall.
- Width quantization: whole µs completed while high; a pulse of N·CLK_PER_US cycles reports N (±1 from synchronizer phase).
- valid and err never asserted in the same cycle; timeout err and pulse evaluation in same cycle -> evaluation wins, timeout deferred to next cycle only if still applicable.
- Rising edge in same cycle as per_cnt reaching TIMEOUT_US: edge wins, no timeout.
- rst_n assertion mid-pulse: all state cleared immediately; first pulse after release is discarded via SYNC.
- Generator pulse of contmsec 0..1000 (1001 µs) decodes to 00; 2001 µs to 11.

## Structure
- Shared package pwm_pkg: CLK_PER_US, PERIOD_US (20000), the four nominal widths (1000/1333/1666/2000), the three decode thresholds, FSM state enum.
- Sub-module pwm_in_sync: 2-FF synchronizer plus rise/fall edge detector (rst_n async clear, output 0).
- Top contains prescaler, counters, FSM, decode, output registers.

## Test plan
- Reset release with pwm_in high for 800 µs then 20 ms frames of 1001 µs -> first pulse ignored, then valid each frame, pos=00, width_us=1000±1, locked=1.
- Frames sweeping 1334, 1667, 2001 µs -> pos=01, 10, 11 in order, one valid per frame, 4 clk after fall.
- Pulse of 300 µs and of 3000 µs -> err strobe each, no valid, pos/width_us unchanged, locked stays 1.
- Hold pwm_in low 30 ms after lock -> single err at 25000 µs after last rise, locked=0; next legal pulse -> valid, locked=1.
- Boundary widths 1166/1167 and 1832/1833 µs (generated as exact cycle counts) -> pos 00/01 and 10/11.
- Assert rst_n low mid-pulse for 3 clk -> all outputs zero next cycle, no valid for the interrupted pulse, normal decode on following frame.
